// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: entry kinds, the stored entry record, sizing.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int IDX_W     = 4;
    localparam int DATA_W    = 32;
    localparam int REG_W     = 5;
    localparam int CNT_W     = IDX_W + 1;

    typedef enum logic [1:0] {
        ROB_REG    = 2'd0,
        ROB_STORE  = 2'd1,
        ROB_BRANCH = 2'd2,
        ROB_JALR   = 2'd3
    } rob_kind_e;

    // One ROB slot: dispatch-time fields followed by CDB-captured result fields
    typedef struct packed {
        rob_kind_e          kind;
        logic [REG_W-1:0]   rd;
        logic [DATA_W-1:0]  pc;
        logic               pred;
        logic [DATA_W-1:0]  value;
        logic               taken;
        logic [DATA_W-1:0]  target;
    } rob_entry_t;

    localparam int ROB_BUS_W = $bits(rob_entry_t);

    // JALR always redirects: the predictor never supplies its target
    function automatic logic is_mispredict(input rob_entry_t e);
        return (e.kind == ROB_JALR) ||
               ((e.kind == ROB_BRANCH) && (e.taken != e.pred));
    endfunction

    function automatic logic [DATA_W-1:0] redirect_of(input rob_entry_t e);
        return e.taken ? e.target : (e.pc + 32'd4);
    endfunction

endpackage

// File: rtl/reorder_buffer_rob_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the circular reorder buffer.
// Latency: pointers update on the edge of the alloc/retire; full is combinational from count.
// Backpressure: full tells the caller to stop allocating; flush overrides everything.
import reorder_buffer_pkg::*;

module rob_ptr_ctrl (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc,
    input  logic             retire,
    input  logic             flush,
    output logic [IDX_W-1:0] head,
    output logic [IDX_W-1:0] tail,
    output logic             full
);

    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state pointers: flush empties the buffer, otherwise modular increments
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (retire) head_d = head_q + 1'b1;
            if (alloc)  tail_d = tail_q + 1'b1;
            case ({alloc, retire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head = head_q;
    assign tail = tail_q;
    assign full = (count_q == CNT_W'(ROB_DEPTH));

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates tags, captures CDB results, retires one entry per cycle.
// Latency: CDB write at edge k -> registered commit outputs after edge k+1; lookups combinational.
// Backpressure: rob_full / flush drop dispatch; rdy=0 freezes all state. ROB_BYPASS_EN adds CDB->lookup forwarding.
import reorder_buffer_pkg::*;

module reorder_buffer (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              disp_en,
    input  logic [1:0]        disp_kind,
    input  logic [REG_W-1:0]  disp_rd,
    input  logic [DATA_W-1:0] disp_pc,
    input  logic              disp_pred,
    output logic [IDX_W-1:0]  rob_nxtpos,
    output logic              rob_full,
    input  logic [IDX_W-1:0]  rs1_tag,
    output logic              rs1_ready,
    output logic [DATA_W-1:0] rs1_value,
    input  logic [IDX_W-1:0]  rs2_tag,
    output logic              rs2_ready,
    output logic [DATA_W-1:0] rs2_value,
    input  logic              cdb_en,
    input  logic [IDX_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    input  logic              cdb_taken,
    input  logic [DATA_W-1:0] cdb_target,
    output logic              cmt_reg_en,
    output logic [REG_W-1:0]  cmt_rd,
    output logic [DATA_W-1:0] cmt_value,
    output logic [IDX_W-1:0]  cmt_tag,
    output logic              cmt_store_en,
    output logic              flush,
    output logic [DATA_W-1:0] redirect_pc
);

    logic [IDX_W-1:0] head, tail;
    logic             full;
    logic             alloc, retire, mispredict, cdb_hit;
    rob_entry_t       head_ent;

    logic [ROB_DEPTH-1:0] valid_q, valid_d;
    logic [ROB_DEPTH-1:0] ready_q, ready_d;
    rob_entry_t           ent_q [ROB_DEPTH];
    rob_entry_t           ent_d [ROB_DEPTH];

    logic              cmt_reg_en_q, cmt_reg_en_d;
    logic              cmt_store_en_q, cmt_store_en_d;
    logic              flush_q, flush_d;
    logic [REG_W-1:0]  cmt_rd_q, cmt_rd_d;
    logic [DATA_W-1:0] cmt_value_q, cmt_value_d;
    logic [IDX_W-1:0]  cmt_tag_q, cmt_tag_d;
    logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;

    rob_ptr_ctrl u_ptr (
        .clk    (clk),
        .rst_n  (rst_n),
        .alloc  (alloc),
        .retire (retire),
        .flush  (mispredict),
        .head   (head),
        .tail   (tail),
        .full   (full)
    );

    // Per-cycle events, all decided from pre-edge state; dispatch is dropped during the flush cycle
    always_comb begin
        head_ent   = ent_q[head];
        retire     = rdy & valid_q[head] & ready_q[head];
        mispredict = retire & is_mispredict(head_ent);
        alloc      = rdy & disp_en & ~full & ~flush_q;
        cdb_hit    = rdy & cdb_en & valid_q[cdb_tag];
    end

    // Entry storage update: CDB capture, retire release, allocation, then flush wipes validity
    always_comb begin
        valid_d = valid_q;
        ready_d = ready_q;
        for (int i = 0; i < ROB_DEPTH; i++) ent_d[i] = ent_q[i];
        if (cdb_hit) begin
            ent_d[cdb_tag].value  = cdb_value;
            ent_d[cdb_tag].taken  = cdb_taken;
            ent_d[cdb_tag].target = cdb_target;
            ready_d[cdb_tag]      = 1'b1;
        end
        if (retire) begin
            valid_d[head] = 1'b0;
            ready_d[head] = 1'b0;
        end
        if (alloc) begin
            ent_d[tail] = '{kind:   rob_kind_e'(disp_kind),
                            rd:     disp_rd,
                            pc:     disp_pc,
                            pred:   disp_pred,
                            value:  '0,
                            taken:  1'b0,
                            target: '0};
            valid_d[tail] = 1'b1;
            ready_d[tail] = 1'b0;
        end
        if (mispredict) begin
            valid_d = '0;
            ready_d = '0;
        end
    end

    // Entry registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ready_q <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) ent_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            ready_q <= ready_d;
            for (int i = 0; i < ROB_DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end

    // Commit outputs: strobes last one cycle, data fields hold until the next retire
    always_comb begin
        cmt_reg_en_d   = 1'b0;
        cmt_store_en_d = 1'b0;
        flush_d        = 1'b0;
        cmt_rd_d       = cmt_rd_q;
        cmt_value_d    = cmt_value_q;
        cmt_tag_d      = cmt_tag_q;
        redirect_pc_d  = redirect_pc_q;
        if (retire) begin
            cmt_tag_d      = head;
            cmt_rd_d       = head_ent.rd;
            cmt_value_d    = head_ent.value;
            cmt_reg_en_d   = ((head_ent.kind == ROB_REG) || (head_ent.kind == ROB_JALR)) &&
                             (head_ent.rd != '0);
            cmt_store_en_d = (head_ent.kind == ROB_STORE);
        end
        if (mispredict) begin
            flush_d       = 1'b1;
            redirect_pc_d = redirect_of(head_ent);
        end
    end

    // Commit output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmt_reg_en_q   <= 1'b0;
            cmt_store_en_q <= 1'b0;
            flush_q        <= 1'b0;
            cmt_rd_q       <= '0;
            cmt_value_q    <= '0;
            cmt_tag_q      <= '0;
            redirect_pc_q  <= '0;
        end else begin
            cmt_reg_en_q   <= cmt_reg_en_d;
            cmt_store_en_q <= cmt_store_en_d;
            flush_q        <= flush_d;
            cmt_rd_q       <= cmt_rd_d;
            cmt_value_q    <= cmt_value_d;
            cmt_tag_q      <= cmt_tag_d;
            redirect_pc_q  <= redirect_pc_d;
        end
    end

    // Operand lookups from stored entries, optionally forwarding this cycle's CDB broadcast
    always_comb begin
        rs1_ready = valid_q[rs1_tag] & ready_q[rs1_tag];
        rs1_value = ent_q[rs1_tag].value;
        rs2_ready = valid_q[rs2_tag] & ready_q[rs2_tag];
        rs2_value = ent_q[rs2_tag].value;
`ifdef ROB_BYPASS_EN
        if (cdb_en && valid_q[rs1_tag] && (cdb_tag == rs1_tag)) begin
            rs1_ready = 1'b1;
            rs1_value = cdb_value;
        end
        if (cdb_en && valid_q[rs2_tag] && (cdb_tag == rs2_tag)) begin
            rs2_ready = 1'b1;
            rs2_value = cdb_value;
        end
`endif
    end

    assign rob_nxtpos   = tail;
    assign rob_full     = full;
    assign cmt_reg_en   = cmt_reg_en_q;
    assign cmt_store_en = cmt_store_en_q;
    assign flush        = flush_q;
    assign cmt_rd       = cmt_rd_q;
    assign cmt_value    = cmt_value_q;
    assign cmt_tag      = cmt_tag_q;
    assign redirect_pc  = redirect_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: queue-based reference model plus directed scenarios.
// Latency: checks each cycle one time unit after driving, away from the rising edge.
// Backpressure: exercises rob_full, flush-cycle dispatch drop and rdy=0 freeze.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        disp_en;
    logic [1:0]  disp_kind;
    logic [4:0]  disp_rd;
    logic [31:0] disp_pc;
    logic        disp_pred;
    logic [3:0]  rob_nxtpos;
    logic        rob_full;
    logic [3:0]  rs1_tag, rs2_tag;
    logic        rs1_ready, rs2_ready;
    logic [31:0] rs1_value, rs2_value;
    logic        cdb_en;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        cdb_taken;
    logic [31:0] cdb_target;
    logic        cmt_reg_en;
    logic [4:0]  cmt_rd;
    logic [31:0] cmt_value;
    logic [3:0]  cmt_tag;
    logic        cmt_store_en;
    logic        flush;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .disp_en(disp_en), .disp_kind(disp_kind), .disp_rd(disp_rd),
        .disp_pc(disp_pc), .disp_pred(disp_pred),
        .rob_nxtpos(rob_nxtpos), .rob_full(rob_full),
        .rs1_tag(rs1_tag), .rs1_ready(rs1_ready), .rs1_value(rs1_value),
        .rs2_tag(rs2_tag), .rs2_ready(rs2_ready), .rs2_value(rs2_value),
        .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_taken(cdb_taken), .cdb_target(cdb_target),
        .cmt_reg_en(cmt_reg_en), .cmt_rd(cmt_rd), .cmt_value(cmt_value),
        .cmt_tag(cmt_tag), .cmt_store_en(cmt_store_en),
        .flush(flush), .redirect_pc(redirect_pc)
    );

    // Reference model: in-flight instructions oldest first, each remembering its tag
    typedef struct {
        int          tag;
        int          kind;
        int          rd;
        logic [31:0] pc;
        bit          pred;
        bit          done;
        logic [31:0] value;
        bit          taken;
        logic [31:0] target;
    } m_ent_t;

    m_ent_t      m_q[$];
    int          m_next_tag;
    bit          e_reg_en, e_store_en, e_flush, e_retired;
    int          e_rd, e_tag;
    logic [31:0] e_value, e_redirect;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_next_tag = 0;
        e_reg_en = 0; e_store_en = 0; e_flush = 0; e_retired = 0;
        e_rd = 0; e_tag = 0; e_value = 0; e_redirect = 0;
    endtask

    task automatic model_lookup(input int tag, output bit r, output logic [31:0] v);
        r = 0;
        v = 0;
        foreach (m_q[i]) if (m_q[i].tag == tag) begin
            r = m_q[i].done;
            v = m_q[i].value;
`ifdef ROB_BYPASS_EN
            if (cdb_en && cdb_tag == tag) begin
                r = 1;
                v = cdb_value;
            end
`endif
        end
    endtask

    // Apply one clock edge of the architectural rules to the model
    task automatic model_step();
        bit     was_flush, do_ret, do_alloc, mis;
        m_ent_t h, n;
        was_flush  = e_flush;
        e_reg_en   = 0;
        e_store_en = 0;
        e_flush    = 0;
        e_retired  = 0;
        if (!rdy) return;
        do_ret   = (m_q.size() > 0) && m_q[0].done;
        do_alloc = disp_en && (m_q.size() < 16) && !was_flush;
        if (do_ret) h = m_q[0];
        if (cdb_en) foreach (m_q[i]) if (m_q[i].tag == int'(cdb_tag)) begin
            m_q[i].done   = 1;
            m_q[i].value  = cdb_value;
            m_q[i].taken  = cdb_taken;
            m_q[i].target = cdb_target;
        end
        mis = 0;
        if (do_ret) begin
            void'(m_q.pop_front());
            e_retired  = 1;
            e_tag      = h.tag;
            e_rd       = h.rd;
            e_value    = h.value;
            e_reg_en   = (h.kind == 0 || h.kind == 3) && h.rd != 0;
            e_store_en = (h.kind == 1);
            mis = (h.kind == 3) || (h.kind == 2 && h.taken != h.pred);
            if (mis) begin
                e_flush    = 1;
                e_redirect = h.taken ? h.target : h.pc + 32'd4;
            end
        end
        if (do_alloc) begin
            n.tag = m_next_tag; n.kind = int'(disp_kind); n.rd = int'(disp_rd);
            n.pc = disp_pc; n.pred = disp_pred; n.done = 0;
            n.value = 0; n.taken = 0; n.target = 0;
            m_q.push_back(n);
            m_next_tag = (m_next_tag + 1) % 16;
        end
        if (mis) begin
            m_q.delete();
            m_next_tag = 0;
        end
    endtask

    // Compare every DUT output against the model for the current cycle
    task automatic compare();
        bit          r;
        logic [31:0] v;
        chk("rob_nxtpos", rob_nxtpos, m_next_tag);
        chk("rob_full", rob_full, (m_q.size() == 16));
        chk("cmt_reg_en", cmt_reg_en, e_reg_en);
        chk("cmt_store_en", cmt_store_en, e_store_en);
        chk("flush", flush, e_flush);
        if (e_retired) chk("cmt_tag", cmt_tag, e_tag);
        if (e_reg_en) begin
            chk("cmt_rd", cmt_rd, e_rd);
            chk("cmt_value", cmt_value, e_value);
        end
        if (e_flush) chk("redirect_pc", redirect_pc, e_redirect);
        model_lookup(int'(rs1_tag), r, v);
        chk("rs1_ready", rs1_ready, r);
        if (r) chk("rs1_value", rs1_value, v);
        model_lookup(int'(rs2_tag), r, v);
        chk("rs2_ready", rs2_ready, r);
        if (r) chk("rs2_value", rs2_value, v);
    endtask

    // Settle, compare, advance the model, then cross one rising edge
    task automatic step();
        #1;
        compare();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdy = 1; disp_en = 0; disp_kind = 0; disp_rd = 0; disp_pc = 0; disp_pred = 0;
        cdb_en = 0; cdb_tag = 0; cdb_value = 0; cdb_taken = 0; cdb_target = 0;
        rs1_tag = 0; rs2_tag = 0;
    endtask

    task automatic set_disp(input int kind, input int rd, input logic [31:0] pc, input bit pred);
        disp_en = 1; disp_kind = 2'(kind); disp_rd = 5'(rd); disp_pc = pc; disp_pred = pred;
    endtask

    task automatic set_cdb(input int tag, input logic [31:0] val, input bit tk, input logic [31:0] tgt);
        cdb_en = 1; cdb_tag = 4'(tag); cdb_value = val; cdb_taken = tk; cdb_target = tgt;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        #1;
        chk("rst_nxtpos", rob_nxtpos, 0);
        chk("rst_full", rob_full, 0);
        chk("rst_cmt_reg_en", cmt_reg_en, 0);
        chk("rst_cmt_store_en", cmt_store_en, 0);
        chk("rst_flush", flush, 0);
        chk("rst_redirect", redirect_pc, 0);
        chk("rst_cmt_tag", cmt_tag, 0);
        model_reset();
        #20;
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r;
        bit phase_a;
        rst_n = 0;
        do_reset();

        // 1: single REG instruction end to end
        idle(); set_disp(0, 3, 32'h100, 0); step();
        chk("t1_nxtpos", rob_nxtpos, 1);
        chk("t1_model_nxtpos", m_next_tag, 1);
        idle(); set_cdb(0, 32'h55, 0, 0); step();
        chk("t1_no_early_commit", cmt_reg_en, 0);
        idle(); step();
        chk("t1_reg_en", cmt_reg_en, 1);
        chk("t1_rd", cmt_rd, 3);
        chk("t1_value", cmt_value, 32'h55);
        chk("t1_tag", cmt_tag, 0);
        idle(); step();
        chk("t1_pulse_once", cmt_reg_en, 0);

        // 2: fill to full, overflow dropped, retire frees a slot, tail wraps
        do_reset();
        for (int i = 0; i < 16; i++) begin
            idle(); set_disp(0, i + 1, 32'h1000 + 4 * i, 0); step();
        end
        chk("t2_full", rob_full, 1);
        chk("t2_tail_wrapped", rob_nxtpos, 0);
        chk("t2_model_size", m_q.size(), 16);
        idle(); set_disp(0, 9, 32'h2000, 0); set_cdb(0, 32'hA0, 0, 0); step();
        chk("t2_drop_full", rob_full, 1);
        idle(); set_disp(0, 9, 32'h2000, 0); step();
        chk("t2_freed", rob_full, 0);
        chk("t2_ret_tag", cmt_tag, 0);
        chk("t2_alloc_refused", rob_nxtpos, 0);
        idle(); set_disp(0, 9, 32'h2000, 0); step();
        chk("t2_reused_tag0", rob_nxtpos, 1);
        chk("t2_full_again", rob_full, 1);

        // 3: out-of-order completion retires in order
        do_reset();
        idle(); set_disp(0, 4, 32'h300, 0); step();
        idle(); set_disp(0, 5, 32'h304, 0); step();
        idle(); set_cdb(1, 32'h11, 0, 0); step();
        idle(); step();
        chk("t3_wait_head", cmt_reg_en, 0);
        idle(); set_cdb(0, 32'h10, 0, 0); step();
        idle(); step();
        chk("t3_first_tag", cmt_tag, 0);
        chk("t3_first_val", cmt_value, 32'h10);
        idle(); step();
        chk("t3_second_tag", cmt_tag, 1);
        chk("t3_second_en", cmt_reg_en, 1);
        chk("t3_second_val", cmt_value, 32'h11);

        // 4: branch mispredicts both ways; dispatch during flush ignored
        do_reset();
        idle(); set_disp(2, 0, 32'h200, 0); step();
        idle(); set_disp(0, 7, 32'h204, 0); set_cdb(0, 0, 1, 32'h240); step();
        idle(); set_disp(0, 8, 32'h208, 0); step();
        chk("t4_flush", flush, 1);
        chk("t4_redirect", redirect_pc, 32'h240);
        chk("t4_emptied", rob_nxtpos, 0);
        chk("t4_model_redirect", e_redirect, 32'h240);
        idle(); set_disp(0, 8, 32'h208, 0); step();
        chk("t4_drop_in_flush", rob_nxtpos, 0);
        chk("t4_flush_once", flush, 0);
        idle(); set_disp(2, 0, 32'h200, 1); step();
        idle(); set_cdb(0, 0, 0, 32'h999); step();
        idle(); step();
        chk("t4_flush_nt", flush, 1);
        chk("t4_redirect_nt", redirect_pc, 32'h204);

        // 5: STORE releases to LSB; REG to x0 writes nothing
        do_reset();
        idle(); set_disp(1, 6, 32'h400, 0); step();
        idle(); set_disp(0, 0, 32'h404, 0); step();
        idle(); set_cdb(0, 32'h1, 0, 0); step();
        idle(); set_cdb(1, 32'h2, 0, 0); step();
        chk("t5_store_en", cmt_store_en, 1);
        chk("t5_store_no_reg", cmt_reg_en, 0);
        idle(); step();
        chk("t5_x0_no_write", cmt_reg_en, 0);
        chk("t5_x0_tag", cmt_tag, 1);

        // 6: same-cycle CDB lookup, and rdy=0 freeze
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle(); set_disp(0, 10 + i, 32'h500 + 4 * i, 0); step();
        end
        idle(); rs1_tag = 2; set_cdb(2, 32'hBEEF, 0, 0); #1;
`ifdef ROB_BYPASS_EN
        chk("t6_bypass_ready", rs1_ready, 1);
        chk("t6_bypass_value", rs1_value, 32'hBEEF);
`else
        chk("t6_no_bypass", rs1_ready, 0);
`endif
        step();
        chk("t6_stored_ready", rs1_ready, 1);
        chk("t6_stored_value", rs1_value, 32'hBEEF);
        idle(); rdy = 0; set_disp(0, 20, 32'h600, 0); set_cdb(0, 32'h7, 0, 0); step();
        chk("t6_freeze_tail", rob_nxtpos, 3);
        idle(); step();
        chk("t6_frozen_cdb_lost", cmt_reg_en, 0);

        // Random traffic: mixed kinds with frequent flushes, then REG/STORE only to reach full
        do_reset();
        for (int c = 0; c < 1600; c++) begin
            phase_a = (c < 800);
            idle();
            rdy     = ($urandom_range(0, 9) != 0);
            disp_en = ($urandom_range(0, 99) < 65);
            r = $urandom_range(0, 99);
            if (phase_a) disp_kind = (r < 60) ? 2'd0 : (r < 80) ? 2'd1 : (r < 93) ? 2'd2 : 2'd3;
            else         disp_kind = (r < 70) ? 2'd0 : 2'd1;
            disp_rd   = 5'($urandom_range(0, 31));
            disp_pc   = $urandom & 32'hFFFF_FFFC;
            disp_pred = 1'($urandom_range(0, 1));
            cdb_en    = ($urandom_range(0, 99) < (phase_a ? 55 : 30));
            if (m_q.size() > 0 && $urandom_range(0, 99) < 85)
                cdb_tag = 4'(m_q[$urandom_range(0, m_q.size() - 1)].tag);
            else
                cdb_tag = 4'($urandom_range(0, 15));
            cdb_value  = $urandom;
            cdb_taken  = 1'($urandom_range(0, 1));
            cdb_target = $urandom & 32'hFFFF_FFFC;
            rs1_tag = ($urandom_range(0, 99) < 30) ? cdb_tag : 4'($urandom_range(0, 15));
            rs2_tag = 4'($urandom_range(0, 15));
            step();
        end
        idle(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
